// File: rtl/difftest_commit_queue_pkg.sv
// Shared types for the difftest commit queue.
// Record layout and the RUN/HALT state encoding.
package difftest_commit_queue_pkg;

    localparam int DATA_W = 64;
    localparam int NR_GPR = 32;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic              rd_wen;
        logic [4:0]        rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic              mem_req;
        logic              mem_wr;
        logic [DATA_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
        logic [2:0]        mem_size;
        logic              ebreak;
    } commit_rec_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/difftest_commit_queue_fifo.sv
// Synchronous FIFO of retired-instruction records.
// Pointers wrap naturally because DEPTH is a power of two.
module difftest_commit_queue_fifo
    import difftest_commit_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  commit_rec_t push_data_i,
    input  logic        pop_i,
    output commit_rec_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    commit_rec_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign wr_en   = push_i && !full_o;
    assign rd_en   = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/difftest_commit_queue.sv
// Commit-ordered queue feeding the difftest commit and mem-trace hooks.
// Shadow GPRs update on the same edge as the pop, so outputs stay consistent.
module difftest_commit_queue #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 4,
    parameter int STALL_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_pc,
    input  logic                in_rd_wen,
    input  logic [4:0]          in_rd_addr,
    input  logic [DATA_W-1:0]   in_rd_data,
    input  logic                in_mem_req,
    input  logic                in_mem_wr,
    input  logic [DATA_W-1:0]   in_mem_addr,
    input  logic [DATA_W-1:0]   in_mem_data,
    input  logic [2:0]          in_mem_size,
    input  logic                in_ebreak,
    input  logic                drain_en,
    output logic                out_commit,
    output logic [DATA_W-1:0]   out_pc,
    output logic [32*DATA_W-1:0] out_gpr,
    output logic                out_mem_req,
    output logic                out_mem_wr,
    output logic [DATA_W-1:0]   out_mem_addr,
    output logic [DATA_W-1:0]   out_mem_data,
    output logic [2:0]          out_mem_size,
    output logic                out_ebreak,
    output logic                halted,
    output logic [STALL_W-1:0]  stall_cnt
);

    import difftest_commit_queue_pkg::*;

    commit_rec_t        in_rec;
    commit_rec_t        head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    state_e             state_q;
    logic [DATA_W-1:0]  gpr_q [NR_GPR];
    logic               commit_q;
    logic [DATA_W-1:0]  pc_q;
    logic               mem_req_q;
    logic               mem_wr_q;
    logic [DATA_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_data_q;
    logic [2:0]         mem_size_q;
    logic               ebreak_q;
    logic [STALL_W-1:0] stall_q;
    logic [STALL_W-1:0] stall_d;

    always_comb begin
        in_rec          = '0;
        in_rec.pc       = in_pc;
        in_rec.rd_wen   = in_rd_wen;
        in_rec.rd_addr  = in_rd_addr;
        in_rec.rd_data  = in_rd_data;
        in_rec.mem_req  = in_mem_req;
        in_rec.mem_wr   = in_mem_wr;
        in_rec.mem_addr = in_mem_addr;
        in_rec.mem_data = in_mem_data;
        in_rec.mem_size = in_mem_size;
        in_rec.ebreak   = in_ebreak;
    end

    assign in_ready = (state_q == RUN) && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == RUN) && !empty && drain_en;

    difftest_commit_queue_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(in_rec),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= RUN;
            commit_q   <= 1'b0;
            pc_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_size_q <= '0;
            ebreak_q   <= 1'b0;
            stall_q    <= '0;
        end else begin
            commit_q  <= pop;
            mem_req_q <= pop && head.mem_req;
            ebreak_q  <= pop && head.ebreak;
            stall_q   <= stall_d;
            if (pop) begin
                pc_q       <= head.pc;
                mem_wr_q   <= head.mem_wr;
                mem_addr_q <= head.mem_addr;
                mem_data_q <= head.mem_data;
                mem_size_q <= head.mem_size;
                if (head.ebreak) begin
                    state_q <= HALT;
                end
            end
        end
    end

    // x0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NR_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (pop && head.rd_wen && (head.rd_addr != 5'd0)) begin
            gpr_q[head.rd_addr] <= head.rd_data;
        end
    end

    for (genvar g = 0; g < NR_GPR; g++) begin : g_gpr
        assign out_gpr[DATA_W*g +: DATA_W] = gpr_q[g];
    end

    assign out_commit   = commit_q;
    assign out_pc       = pc_q;
    assign out_mem_req  = mem_req_q;
    assign out_mem_wr   = mem_wr_q;
    assign out_mem_addr = mem_addr_q;
    assign out_mem_data = mem_data_q;
    assign out_mem_size = mem_size_q;
    assign out_ebreak   = ebreak_q;
    assign halted       = (state_q == HALT);
    assign stall_cnt    = stall_q;

endmodule
